// File: rtl/vga_fb_reader.sv
// VGA framebuffer read-out: raster counters, RAM fetch, sync/RGB output.
// Two-stage pipeline keeps syncs, display enable and pixel data aligned.
module vga_fb_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_W    = 12,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [PIX_W-1:0]  i_rd_data,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_de,
    output logic [PIX_W-1:0]  o_rgb,
    output logic              o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W = $clog2(H_TOTAL + 1);
    localparam int V_W = $clog2(V_TOTAL + 1);

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_W-1:0]    h_cnt;
    logic [V_W-1:0]    v_cnt;
    logic [ADDR_W-1:0] addr;

    logic h_end;
    logic v_end;
    logic frame_end;
    logic active;
    logic hs;
    logic vs;
    logic origin;

    logic s1_hs;
    logic s1_vs;
    logic s1_de;
    logic s1_fs;

    // Stage 0: decode the current raster position.
    always_comb begin
        h_end     = (h_cnt == H_LAST);
        v_end     = (v_cnt == V_LAST);
        frame_end = h_end && v_end;
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs        = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs        = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        origin    = (h_cnt == '0) && (v_cnt == '0);
    end

    // Raster counters: h wraps each line, v advances on the h wrap.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_en) begin
            if (h_end) begin
                h_cnt <= '0;
                if (v_end) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Linear pixel address: steps per visible pixel, rewinds at frame end.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr <= '0;
        end else if (i_en) begin
            if (frame_end) begin
                addr <= '0;
            end else if (active) begin
                addr <= addr + 1'b1;
            end
        end
    end

    // Read strobe is one clk wide even with a sparse enable.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_en <= 1'b0;
        end else begin
            o_rd_en <= i_en && active;
        end
    end

    // Stage 1: issue the RAM address and carry timing flags alongside it.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_addr <= '0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            s1_de     <= 1'b0;
            s1_fs     <= 1'b0;
        end else if (i_en) begin
            if (active) begin
                o_rd_addr <= addr;
            end
            s1_hs <= hs;
            s1_vs <= vs;
            s1_de <= active;
            s1_fs <= origin;
        end
    end

    // Stage 2: drive the pins with RAM data aligned to its flags.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_de          <= 1'b0;
            o_rgb         <= '0;
            o_frame_start <= 1'b0;
        end else if (i_en) begin
            o_hsync       <= s1_hs;
            o_vsync       <= s1_vs;
            o_de          <= s1_de;
            o_rgb         <= s1_de ? i_rd_data : '0;
            o_frame_start <= s1_fs;
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader on a tiny 8x6 raster (4x3 visible).
// RAM model answers each read with addr+0x100, held until the next read.
module tb_vga_fb_reader;

    localparam int HA = 4;
    localparam int VA = 3;
    localparam int HT = 8;
    localparam int VT = 6;
    localparam int PW = 12;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_en = 1'b0;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic [PW-1:0] i_rd_data = '0;
    logic          o_hsync;
    logic          o_vsync;
    logic          o_de;
    logic [PW-1:0] o_rgb;
    logic          o_frame_start;

    int n_chk = 0;
    int n_fail = 0;
    int exp_addr = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (o_rd_en === 1'b1) i_rd_data = PW'(o_rd_addr) + 12'h100;
    end

    vga_fb_reader #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_W(PW), .ADDR_W(AW)
    ) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_en),
        .o_rd_en      (o_rd_en),
        .o_rd_addr    (o_rd_addr),
        .i_rd_data    (i_rd_data),
        .o_hsync      (o_hsync),
        .o_vsync      (o_vsync),
        .o_de         (o_de),
        .o_rgb        (o_rgb),
        .o_frame_start(o_frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit en);
        i_en = en;
        @(posedge clk);
        @(negedge clk);
        i_en = 1'b0;
    endtask

    task automatic do_reset();
        i_en = 1'b0;
        i_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        exp_addr = 0;
    endtask

    task automatic chk_idle(input string p);
        chk({p, " rd_en"}, 32'(o_rd_en), 0);
        chk({p, " rd_addr"}, 32'(o_rd_addr), 0);
        chk({p, " hsync"}, 32'(o_hsync), 1);
        chk({p, " vsync"}, 32'(o_vsync), 1);
        chk({p, " de"}, 32'(o_de), 0);
        chk({p, " rgb"}, 32'(o_rgb), 0);
        chk({p, " fs"}, 32'(o_frame_start), 0);
    endtask

    // k = enabled edges since reset; strobe = sampled right after edge k.
    task automatic chk_pins(input string p, input int k, input bit strobe);
        int t0, h0, v0, t, h, v;
        bit act0, de, hs, vs, fs;
        int rgb;
        t0 = k - 1;
        h0 = t0 % HT;
        v0 = (t0 / HT) % VT;
        act0 = (h0 < HA) && (v0 < VA);
        if (strobe && act0) exp_addr = v0 * HA + h0;
        t = k - 2;
        if (t < 0) begin
            de = 0; rgb = 0; hs = 1; vs = 1; fs = 0;
        end else begin
            h = t % HT;
            v = (t / HT) % VT;
            de = (h < HA) && (v < VA);
            rgb = de ? 32'h100 + v * HA + h : 0;
            hs = !(h == 5 || h == 6);
            vs = (v != 4);
            fs = (t % (HT * VT)) == 0;
        end
        chk($sformatf("%s k=%0d rd_en", p, k), 32'(o_rd_en),
            32'(strobe && act0));
        chk($sformatf("%s k=%0d rd_addr", p, k), 32'(o_rd_addr),
            32'(exp_addr));
        chk($sformatf("%s k=%0d de", p, k), 32'(o_de), 32'(de));
        chk($sformatf("%s k=%0d rgb", p, k), 32'(o_rgb), 32'(rgb));
        chk($sformatf("%s k=%0d hsync", p, k), 32'(o_hsync), 32'(hs));
        chk($sformatf("%s k=%0d vsync", p, k), 32'(o_vsync), 32'(vs));
        chk($sformatf("%s k=%0d fs", p, k), 32'(o_frame_start), 32'(fs));
    endtask

    initial begin
        int vs_low;
        int fs_cnt;
        int de_run;

        // Reset state and the first few edges by hand.
        do_reset();
        chk_idle("reset");
        step(1);
        chk("e1 rd_en", 32'(o_rd_en), 1);
        chk("e1 rd_addr", 32'(o_rd_addr), 0);
        step(1);
        chk("e2 de", 32'(o_de), 1);
        chk("e2 rgb", 32'(o_rgb), 32'h100);
        chk("e2 fs", 32'(o_frame_start), 1);
        step(1);
        chk("e3 fs", 32'(o_frame_start), 0);
        chk("e3 rgb", 32'(o_rgb), 32'h101);

        // Full raster, two-plus frames at full rate.
        do_reset();
        vs_low = 0;
        fs_cnt = 0;
        de_run = 0;
        for (int k = 1; k <= 100; k++) begin
            step(1);
            chk_pins("full", k, 1'b1);
            if (k >= 2 && k <= 49 && o_vsync == 1'b0) vs_low++;
            if (k >= 2 && k <= 9 && o_de == 1'b1) de_run++;
            if (o_frame_start == 1'b1) fs_cnt++;
            if (k == 21) chk("last px rgb", 32'(o_rgb), 32'h10B);
            if (k == 20) chk("last px addr", 32'(o_rd_addr), 11);
            if (k == 49) chk("restart addr", 32'(o_rd_addr), 0);
        end
        chk("vsync low ticks", 32'(vs_low), 8);
        chk("de ticks line0", 32'(de_run), 4);
        chk("fs pulses", 32'(fs_cnt), 3);

        // Sparse enable: one strobe every 4 clocks, outputs hold between.
        do_reset();
        for (int n = 1; n <= 60; n++) begin
            step(1);
            chk_pins("sparse", n, 1'b1);
            for (int j = 0; j < 3; j++) begin
                step(0);
                chk_pins("hold", n, 1'b0);
            end
        end

        // Asynchronous reset while a visible pixel is on the pins.
        do_reset();
        for (int k = 1; k <= 3; k++) step(1);
        chk("pre-rst de", 32'(o_de), 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_idle("async rst");
        @(negedge clk);
        i_rst_n = 1'b1;
        exp_addr = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk_pins("post-rst", k, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
